// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver (LSB first) with synchronizer, 3-sample majority vote and one-entry output slot.
// Latency: rx_valid rises 1 clk after the stop-bit sample edge (~9.5 bit times + 3 cycles after the start edge).
// Backpressure: a single byte is held until rx_ack; a good byte arriving while the slot is full is dropped with an rx_overrun pulse.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   rx           asynchronous serial input, idle high
//   rx_ack       consumer has taken rx_data; clears rx_valid
//   rx_data      last good byte, stable while rx_valid=1
//   rx_valid     byte available, held until acked
//   rx_busy      frame in progress (state != IDLE)
//   rx_frame_err 1-cycle pulse: stop bit sampled low
//   rx_overrun   1-cycle pulse: good byte completed while the slot was full
module uart_rx #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  // Terminal counts for the half-bit (start) and full-bit (data/stop) intervals.
  localparam logic [12:0] LP_LAST      = 13'(BAUD_DIV - 1);
  localparam logic [12:0] LP_HALF_LAST = 13'((BAUD_DIV / 2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Input path
  logic        r_sync1;
  logic        r_sync2;     // rx_s: synchronized line
  logic [2:0]  r_hist;      // last three rx_s values
  logic        w_vote;

  // Receiver state
  state_t      r_state;
  logic [12:0] r_baud_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;

  // Registered outputs
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_busy;
  logic        r_frame_err;
  logic        r_overrun;

  // Two-flop synchronizer followed by a 3-deep history for the vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_hist  <= 3'b111;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_hist  <= {r_hist[1:0], r_sync2};
    end
  end

  // A single-cycle disturbance can only ever flip one of the three votes.
  assign w_vote = (r_hist[0] & r_hist[1]) |
                  (r_hist[0] & r_hist[2]) |
                  (r_hist[1] & r_hist[2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;

      // Ack frees the slot; a delivery in the STOP branch below overrides this.
      if (rx_ack && r_valid) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // Uses the raw synchronized line so back-to-back frames start on time.
          if (!r_sync2) begin
            r_state    <= S_START;
            r_baud_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end

        S_START: begin
          if (r_baud_cnt == LP_HALF_LAST) begin
            r_baud_cnt <= '0;
            if (!w_vote) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              // Low pulse too short to be a start bit.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 13'd1;
          end
        end

        S_DATA: begin
          if (r_baud_cnt == LP_LAST) begin
            r_baud_cnt         <= '0;
            r_shift[r_bit_idx] <= w_vote;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 13'd1;
          end
        end

        S_STOP: begin
          if (r_baud_cnt == LP_LAST) begin
            r_baud_cnt <= '0;
            if (w_vote) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              // An ack in this same cycle frees the slot for the new byte.
              if (!r_valid || rx_ack) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 13'd1;
          end
        end

        S_BREAK: begin
          // Hold off until the line returns high so a stuck-low line
          // cannot immediately re-trigger a start bit.
          if (r_sync2) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_busy      = r_busy;
  assign rx_frame_err = r_frame_err;
  assign rx_overrun   = r_overrun;

endmodule
